// File: rtl/crypix_seq_pkg.sv
// +--------------------------------------------------------------------+
// | crypix_seq_pkg : shared widths, state encoding and helper for      |
// | the CRY pixel sequencer.                Revision: 1.0              |
// +--------------------------------------------------------------------+
`default_nettype none

package crypix_seq_pkg;

  localparam int C_PIX_W = 16;
  localparam int C_LP_W  = 10;
  localparam int C_PW_W  = 3;

  typedef enum logic [0:0] {
    ST_BLANK  = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // Saturating increment so the pixel count sticks at its maximum.
  function automatic logic [C_LP_W-1:0] sat_inc(input logic [C_LP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crypix_seq.sv
// +--------------------------------------------------------------------+
// | crypix_seq : pops line-buffer pixels at the pixel-clock rate and   |
// | presents them to the colour converter.  Revision: 1.0              |
// +--------------------------------------------------------------------+
`default_nettype none

module crypix_seq
  import crypix_seq_pkg::*;
(
  input  logic               sys_clk,
  input  logic               resetl,
  input  logic               vclk,
  input  logic               hde,
  input  logic [C_PW_W-1:0]  pwidth,
  input  logic               mode_rgb,
  input  logic [C_PIX_W-1:0] border,
  input  logic               lb_valid,
  input  logic [C_PIX_W-1:0] lb_data,
  output logic               lb_ready,
  input  logic               underflow_clr,
  output logic [C_PIX_W-1:0] cry,
  output logic               rgb,
  output logic               ppd,
  output logic               underflow,
  output logic [C_LP_W-1:0]  line_pix
);

  state_t              r_state,  w_state_nxt;
  logic [C_PIX_W-1:0]  r_cry,    w_cry_nxt;
  logic                r_rgb,    w_rgb_nxt;
  logic                r_ppd,    w_ppd_nxt;
  logic [C_PW_W-1:0]   r_pcnt,   w_pcnt_nxt;
  logic [C_PW_W-1:0]   r_pw,     w_pw_nxt;
  logic [C_LP_W-1:0]   r_lp,     w_lp_nxt;
  logic                r_uf,     w_uf_nxt;
  logic                w_uf_set;
  logic                w_slot;
  logic [C_PW_W-1:0]   w_pcnt_adv;

  assign w_slot     = (r_pcnt == '0);
  assign w_pcnt_adv = (r_pcnt == r_pw) ? '0 : r_pcnt + 1'b1;

  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_state <= ST_BLANK;
      r_cry   <= '0;
      r_rgb   <= 1'b0;
      r_ppd   <= 1'b0;
      r_pcnt  <= '0;
      r_pw    <= '0;
      r_lp    <= '0;
      r_uf    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cry   <= w_cry_nxt;
      r_rgb   <= w_rgb_nxt;
      r_ppd   <= w_ppd_nxt;
      r_pcnt  <= w_pcnt_nxt;
      r_pw    <= w_pw_nxt;
      r_lp    <= w_lp_nxt;
      r_uf    <= w_uf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cry_nxt   = r_cry;
    w_rgb_nxt   = r_rgb;
    w_ppd_nxt   = r_ppd;
    w_pcnt_nxt  = r_pcnt;
    w_pw_nxt    = r_pw;
    w_lp_nxt    = r_lp;
    w_uf_set    = 1'b0;
    lb_ready    = 1'b0;

    if (vclk) begin
      unique case (r_state)
        ST_BLANK: begin
          w_ppd_nxt = 1'b0;
          if (hde) begin
            w_state_nxt = ST_ACTIVE;
            w_pw_nxt    = pwidth;
            w_rgb_nxt   = mode_rgb;
            w_pcnt_nxt  = '0;
            w_lp_nxt    = '0;
          end
        end
        ST_ACTIVE: begin
          if (!hde) begin
            // Line end wins over a pending pop: emit one border pixel.
            w_state_nxt = ST_BLANK;
            w_cry_nxt   = border;
            w_rgb_nxt   = 1'b0;
            w_pcnt_nxt  = '0;
            w_ppd_nxt   = 1'b1;
          end else if (w_slot) begin
            lb_ready   = 1'b1;
            w_cry_nxt  = lb_valid ? lb_data : border;
            w_uf_set   = ~lb_valid;
            w_ppd_nxt  = 1'b1;
            w_lp_nxt   = sat_inc(r_lp);
            w_pcnt_nxt = w_pcnt_adv;
          end else begin
            w_ppd_nxt  = 1'b0;
            w_pcnt_nxt = w_pcnt_adv;
          end
        end
        default: w_state_nxt = ST_BLANK;
      endcase
    end

    w_uf_nxt = w_uf_set ? 1'b1 : (underflow_clr ? 1'b0 : r_uf);
  end

  assign cry       = r_cry;
  assign rgb       = r_rgb;
  assign ppd       = r_ppd;
  assign underflow = r_uf;
  assign line_pix  = r_lp;

endmodule

`default_nettype wire

// File: tb/tb_crypix_seq.sv
// Self-checking bench for crypix_seq: directed table, corner sequences and
// randomized traffic against a slot-index reference model.
`default_nettype none

module tb_crypix_seq;

  logic        sys_clk = 1'b0;
  logic        resetl, vclk, hde, mode_rgb, lb_valid, underflow_clr;
  logic [2:0]  pwidth;
  logic [15:0] border, lb_data;
  logic        lb_ready, rgb, ppd, underflow;
  logic [15:0] cry;
  logic [9:0]  line_pix;

  crypix_seq dut (
    .sys_clk(sys_clk), .resetl(resetl), .vclk(vclk), .hde(hde),
    .pwidth(pwidth), .mode_rgb(mode_rgb), .border(border),
    .lb_valid(lb_valid), .lb_data(lb_data), .lb_ready(lb_ready),
    .underflow_clr(underflow_clr), .cry(cry), .rgb(rgb), .ppd(ppd),
    .underflow(underflow), .line_pix(line_pix)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] fifo[$];
  int pops, ppd_hi, tick_no;
  int pop_ticks[$];

  // Reference model: a line is a sequence of active ticks k = 0,1,2,...;
  // a pixel slot falls on every k that is a multiple of (pw+1).
  bit          m_active;
  int          m_k, m_pw, m_lp;
  logic        m_rgb, m_ppd, m_uf;
  logic [15:0] m_cry;

  typedef struct {
    logic v, h, val;
    logic [15:0] data, brd;
    logic e_rdy;
    logic [15:0] e_cry;
    logic e_ppd;
    logic [9:0] e_lp;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_k = 0; m_pw = 0; m_lp = 0;
    m_rgb = 0; m_ppd = 0; m_uf = 0; m_cry = 16'h0;
  endtask

  function automatic bit m_slot();
    return m_active && ((m_k % (m_pw + 1)) == 0);
  endfunction

  task automatic chk_outputs();
    chk("cry", cry, m_cry);
    chk("rgb", {15'h0, rgb}, {15'h0, m_rgb});
    chk("ppd", {15'h0, ppd}, {15'h0, m_ppd});
    chk("underflow", {15'h0, underflow}, {15'h0, m_uf});
    chk("line_pix", {6'h0, line_pix}, m_lp[15:0]);
  endtask

  // Starts at posedge+1, ends at the next posedge+1.
  task automatic step(input logic v, input logic h, input logic c);
    logic exp_r, popped, uf_set;
    vclk = v; hde = h; underflow_clr = c;
    lb_valid = (fifo.size() > 0);
    lb_data  = lb_valid ? fifo[0] : 16'hDEAD;
    #1;
    exp_r = v && h && m_slot();
    chk("lb_ready", {15'h0, lb_ready}, {15'h0, exp_r});
    popped = lb_ready && lb_valid;
    uf_set = 0;
    if (v) begin
      if (!m_active) begin
        m_ppd = 0;
        if (h) begin
          m_active = 1; m_pw = int'(pwidth); m_rgb = mode_rgb; m_k = 0; m_lp = 0;
        end
      end else if (!h) begin
        m_active = 0; m_cry = border; m_rgb = 0; m_ppd = 1; m_k = 0;
      end else begin
        if (m_slot()) begin
          m_cry  = lb_valid ? lb_data : border;
          uf_set = !lb_valid;
          m_ppd  = 1;
          if (m_lp < 1023) m_lp++;
        end else begin
          m_ppd = 0;
        end
        m_k++;
      end
    end
    if (uf_set) m_uf = 1;
    else if (c) m_uf = 0;
    @(posedge sys_clk); #1;
    tick_no++;
    if (popped) begin
      void'(fifo.pop_front());
      pops++;
      pop_ticks.push_back(tick_no);
    end
    if (ppd) ppd_hi++;
    chk_outputs();
  endtask

  task automatic do_reset();
    resetl = 0; vclk = 0; hde = 0; mode_rgb = 0; pwidth = 0; border = 0;
    lb_valid = 0; lb_data = 0; underflow_clr = 0;
    fifo.delete();
    model_reset();
    repeat (2) @(posedge sys_clk);
    #1;
    chk_outputs();
    chk("rst_lb_ready", {15'h0, lb_ready}, 16'h0);
    resetl = 1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b0, 16'h0000, 1'b0, 10'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b1, 10'd1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 16'h5678, 16'h0000, 1'b1, 16'h5678, 1'b1, 10'd2};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 10'd2};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 10'd2};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 16'hAAAA, 16'hF00F, 1'b0, 16'h0000, 1'b0, 10'd0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 16'hAAAA, 16'hF00F, 1'b1, 16'hAAAA, 1'b1, 10'd1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 16'hBBBB, 16'hF00F, 1'b0, 16'hAAAA, 1'b1, 10'd1};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 16'hBBBB, 16'hF00F, 1'b0, 16'hF00F, 1'b1, 10'd1};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 16'hBBBB, 16'hF00F, 1'b0, 16'hF00F, 1'b0, 10'd1};

    tick_no = 0; pops = 0; ppd_hi = 0;
    do_reset();
    @(posedge sys_clk); #1;

    // Directed table: pwidth=0, CRY mode, explicit FIFO head per row.
    for (int i = 0; i < 10; i++) begin
      vclk = tbl[i].v; hde = tbl[i].h; lb_valid = tbl[i].val;
      lb_data = tbl[i].data; border = tbl[i].brd; underflow_clr = 0;
      #1;
      chk($sformatf("tbl%0d_ready", i), {15'h0, lb_ready}, {15'h0, tbl[i].e_rdy});
      @(posedge sys_clk); #1;
      chk($sformatf("tbl%0d_cry", i), cry, tbl[i].e_cry);
      chk($sformatf("tbl%0d_ppd", i), {15'h0, ppd}, {15'h0, tbl[i].e_ppd});
      chk($sformatf("tbl%0d_lp", i), {6'h0, line_pix}, {6'h0, tbl[i].e_lp});
      chk($sformatf("tbl%0d_uf", i), {15'h0, underflow}, 16'h0);
    end

    // pwidth=3: four pops spaced four ticks apart over 16 active ticks.
    do_reset();
    @(posedge sys_clk); #1;
    pwidth = 3'd3;
    for (int i = 0; i < 4; i++) fifo.push_back(16'h0100 + 16'(i));
    step(1, 1, 0);
    pops = 0; ppd_hi = 0; pop_ticks.delete();
    for (int i = 0; i < 16; i++) step(1, 1, 0);
    chk("pw3_pops", 16'(pops), 16'd4);
    chk("pw3_ppd_count", 16'(ppd_hi), 16'd4);
    for (int i = 1; i < pop_ticks.size(); i++)
      chk("pw3_pop_spacing", 16'(pop_ticks[i] - pop_ticks[i-1]), 16'd4);
    step(1, 0, 0);
    step(1, 0, 0);

    // Underflow on pixel 2, sticky until a clear on a non-tick edge.
    pwidth = 3'd0; border = 16'hF00F;
    fifo.push_back(16'h1111);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("uf_cry_border", cry, 16'hF00F);
    chk("uf_set", {15'h0, underflow}, 16'h1);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("uf_sticky", {15'h0, underflow}, 16'h1);
    step(0, 0, 1);
    chk("uf_cleared", {15'h0, underflow}, 16'h0);

    // mode_rgb changes mid-line only take effect at the next line start.
    mode_rgb = 0;
    step(1, 1, 0);
    mode_rgb = 1;
    for (int i = 0; i < 4; i++) step(1, 1, 0);
    chk("rgb_held", {15'h0, rgb}, 16'h0);
    step(1, 0, 0);
    step(1, 1, 0);
    chk("rgb_new_line", {15'h0, rgb}, 16'h1);
    step(1, 0, 0);

    // Mid-line asynchronous reset, then a clean restart.
    for (int i = 0; i < 3; i++) fifo.push_back(16'h2200 + 16'(i));
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    vclk = 1; hde = 1;
    #1;
    resetl = 0;
    #1;
    model_reset();
    chk_outputs();
    chk("rst_mid_ready", {15'h0, lb_ready}, 16'h0);
    @(posedge sys_clk); #1;
    resetl = 1;
    step(1, 1, 0);
    step(1, 1, 0);
    chk("restart_lp", {6'h0, line_pix}, 16'd1);
    step(1, 0, 0);

    // line_pix saturation with an empty FIFO.
    pwidth = 3'd0;
    step(1, 1, 1);
    for (int i = 0; i < 1030; i++) step(1, 1, 0);
    chk("lp_saturate", {6'h0, line_pix}, 16'd1023);
    step(1, 0, 1);

    // Randomized traffic against the reference model.
    begin
      int run;
      logic h;
      run = 0; h = 0;
      for (int i = 0; i < 2000; i++) begin
        if (run == 0) begin
          h = ~h;
          run = h ? int'($urandom_range(4, 40)) : int'($urandom_range(1, 8));
        end
        if ($urandom_range(0, 3) != 0 && fifo.size() < 8)
          fifo.push_back(16'($urandom));
        pwidth   = 3'($urandom_range(0, 7));
        mode_rgb = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) border = 16'($urandom);
        if ($urandom_range(0, 3) != 0) run--;
        step(1'($urandom_range(0, 3) != 0), h, 1'($urandom_range(0, 31) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
